// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
// Purpose: shared types and helpers for the PWM capture block.
//   pwm_cap_state_e : capture FSM state encoding
//   cnt_max()       : all-ones value of a dw-bit counter (saturation limit)
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        CapIdle,
        CapWaitRise,
        CapMeasHigh,
        CapMeasLow
    } pwm_cap_state_e;

    localparam int unsigned CntDwDefault = 16;

    function automatic int unsigned cnt_max(input int unsigned dw);
        return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if
// Purpose: control/result bundle of the PWM capture block.
//   en_i      capture enable (low forces idle)
//   invert_i  invert sampled input before edge detection
//   clr_i     one-cycle clear of sticky ovf_o
//   pwm_i     asynchronous PWM input
//   period_o  last measured period, cycles
//   high_o    last measured high time, cycles
//   valid_o   one-cycle strobe when period_o/high_o update
//   ovf_o     sticky: a counter saturated before the expected edge
//   level_o   synchronized, optionally inverted input level
// master drives the controls and the PWM input; slave is the capture block.
interface pwm_capture_if #(
    parameter int unsigned CntDw = 16
);
    logic             en_i;
    logic             invert_i;
    logic             clr_i;
    logic             pwm_i;
    logic [CntDw-1:0] period_o;
    logic [CntDw-1:0] high_o;
    logic             valid_o;
    logic             ovf_o;
    logic             level_o;

    modport master (
        output en_i, invert_i, clr_i, pwm_i,
        input  period_o, high_o, valid_o, ovf_o, level_o
    );

    modport slave (
        input  en_i, invert_i, clr_i, pwm_i,
        output period_o, high_o, valid_o, ovf_o, level_o
    );
endinterface

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync
// Purpose: synchronize the asynchronous PWM input, apply optional inversion
// and detect edges on the synchronized level.
//   clk_i, rst_i  clock, async active-high reset
//   pwm_i         asynchronous PWM input
//   invert_i      invert the synchronized level
//   s_q           registered (synchronized, inverted-as-configured) level
//   rise, fall    single-cycle edge flags of that level
// SyncStages must be at least 2.
module pwm_capture_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    input  logic invert_i,
    output logic s_q,
    output logic rise,
    output logic fall
);
    logic [SyncStages-1:0] sync_q;
    logic                  s;

    // Inversion sits after the synchronizer so toggling invert_i never
    // touches the metastability chain; it can produce a spurious edge,
    // which the FSM tolerates like any other edge.
    assign s    = sync_q[SyncStages-1] ^ invert_i;
    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            s_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pwm_i};
            s_q    <= s;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Purpose: measure period (rise to rise) and high time (rise to fall) of an
// external PWM waveform in clk_i cycles, publishing each completed period
// with a one-cycle valid strobe.
//   clk_i, rst_i  clock, async active-high reset
//   bus           pwm_capture_if slave: controls, PWM input and results
//
// state       | meaning
// ------------+----------------------------------------------------------
// CapIdle     | disabled, counter cleared
// CapWaitRise | armed, waiting for a rise to start a measurement
// CapMeasHigh | counting the high phase, waiting for fall
// CapMeasLow  | counting the low phase, waiting for the closing rise
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CntDw      = CntDwDefault,
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    pwm_capture_if.slave bus
);
    localparam logic [CntDw-1:0] CntMax = CntDw'(cnt_max(CntDw));
    localparam logic [CntDw-1:0] CntOne = CntDw'(1);

    pwm_cap_state_e   state;
    logic [CntDw-1:0] cnt;
    logic [CntDw-1:0] high_cnt;
    logic [CntDw-1:0] cnt_inc;
    logic [CntDw-1:0] period_q;
    logic [CntDw-1:0] high_q;
    logic             valid_q;
    logic             ovf_q;
    logic             s_q;
    logic             rise;
    logic             fall;
    logic             sat;

    pwm_capture_sync #(
        .SyncStages(SyncStages)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pwm_i   (bus.pwm_i),
        .invert_i(bus.invert_i),
        .s_q     (s_q),
        .rise    (rise),
        .fall    (fall)
    );

    assign cnt_inc = (cnt == CntMax) ? cnt : cnt + CntOne;

    // Saturation only counts when the edge that would end the phase is
    // absent; an edge in the same cycle is processed normally.
    assign sat = bus.en_i && (cnt == CntMax) &&
                 (((state == CapMeasHigh) && !fall) ||
                  ((state == CapMeasLow)  && !rise));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= CapIdle;
            cnt      <= '0;
            high_cnt <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (sat) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_i) begin
                ovf_q <= 1'b0;
            end

            if (!bus.en_i) begin
                state <= CapIdle;
                cnt   <= '0;
            end else begin
                case (state)
                    CapIdle: begin
                        cnt   <= '0;
                        state <= CapWaitRise;
                    end
                    CapWaitRise: begin
                        if (rise) begin
                            cnt   <= CntOne;
                            state <= CapMeasHigh;
                        end
                    end
                    CapMeasHigh: begin
                        if (fall) begin
                            high_cnt <= cnt;
                            cnt      <= cnt_inc;
                            state    <= CapMeasLow;
                        end else if (sat) begin
                            cnt   <= '0;
                            state <= CapWaitRise;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    CapMeasLow: begin
                        if (rise) begin
                            period_q <= cnt;
                            high_q   <= high_cnt;
                            valid_q  <= 1'b1;
                            cnt      <= CntOne;
                            state    <= CapMeasHigh;
                        end else if (sat) begin
                            cnt   <= '0;
                            state <= CapWaitRise;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= CapIdle;
                    end
                endcase
            end
        end
    end

    assign bus.period_o = period_q;
    assign bus.high_o   = high_q;
    assign bus.valid_o  = valid_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.level_o  = s_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Purpose: directed bench for pwm_capture. Instance a uses CntDw=8 for the
// measurement, enable and overflow cases; instance b uses CntDw=4 so a
// 15-cycle period lands exactly on the saturation value.
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm = 1'b0;
    logic invert = 1'b0;
    logic clr = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    always #5 clk = ~clk;

    pwm_capture_if #(.CntDw(8)) bus_a ();
    pwm_capture_if #(.CntDw(4)) bus_b ();

    assign bus_a.en_i     = en_a;
    assign bus_a.invert_i = invert;
    assign bus_a.clr_i    = clr;
    assign bus_a.pwm_i    = pwm;
    assign bus_b.en_i     = en_b;
    assign bus_b.invert_i = invert;
    assign bus_b.clr_i    = clr;
    assign bus_b.pwm_i    = pwm;

    pwm_capture #(.CntDw(8), .SyncStages(2)) dut_a (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_a)
    );

    pwm_capture #(.CntDw(4), .SyncStages(2)) dut_b (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_b)
    );

    int tests = 0;
    int fails = 0;

    // Expected values for every valid strobe during the current case.
    int exp_per = 0;
    int exp_high = 0;

    int va_cnt = 0;
    int va_bad = 0;
    int vb_cnt = 0;
    int vb_bad = 0;
    logic va_prev = 1'b0;
    logic vb_prev = 1'b0;

    always @(negedge clk) begin
        if (bus_a.valid_o === 1'b1) begin
            va_cnt <= va_cnt + 1;
            if (int'(bus_a.period_o) != exp_per || int'(bus_a.high_o) != exp_high || va_prev)
                va_bad <= va_bad + 1;
        end
        if (bus_b.valid_o === 1'b1) begin
            vb_cnt <= vb_cnt + 1;
            if (int'(bus_b.period_o) != exp_per || int'(bus_b.high_o) != exp_high || vb_prev)
                vb_bad <= vb_bad + 1;
        end
        va_prev <= bus_a.valid_o;
        vb_prev <= bus_b.valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // nper full periods starting with a rise, then one closing rise left high.
    task automatic drive_pwm(input int per, input int hi, input int nper);
        for (int i = 0; i < nper; i++) begin
            pwm = 1'b1;
            tick(hi);
            pwm = 1'b0;
            tick(per - hi);
        end
        pwm = 1'b1;
    endtask

    int base;

    initial begin
        // reset values
        tick(3);
        chk("rst_period", 32'(bus_a.period_o), 0);
        chk("rst_high",   32'(bus_a.high_o), 0);
        chk("rst_valid",  32'(bus_a.valid_o), 0);
        chk("rst_ovf",    32'(bus_a.ovf_o), 0);
        chk("rst_level",  32'(bus_a.level_o), 0);
        rst = 1'b0;
        tick(2);

        // period 100, high 30
        exp_per = 100; exp_high = 30;
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        drive_pwm(100, 30, 3);
        tick(5);
        chk("p100_count",  32'(va_cnt - base), 3);
        chk("p100_values", 32'(va_bad), 0);
        chk("p100_period", 32'(bus_a.period_o), 100);
        chk("p100_high",   32'(bus_a.high_o), 30);
        en_a = 1'b0; pwm = 1'b0;
        tick(5);

        // inverted: rises of s are pwm falls, high time becomes the low phase
        invert = 1'b1;
        tick(5);
        chk("inv_level", 32'(bus_a.level_o), 1);
        exp_per = 100; exp_high = 70;
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        drive_pwm(100, 30, 3);
        tick(5);
        chk("inv_count",  32'(va_cnt - base), 2);
        chk("inv_values", 32'(va_bad), 0);
        chk("inv_high",   32'(bus_a.high_o), 70);
        en_a = 1'b0;
        tick(2);
        invert = 1'b0; pwm = 1'b0;
        tick(5);
        chk("inv_no_ovf", 32'(bus_a.ovf_o), 0);

        // held high after one rise: ovf after posedge 258 following the pwm step
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        pwm = 1'b1;
        tick(257);
        chk("ovf_before", 32'(bus_a.ovf_o), 0);
        tick(1);
        chk("ovf_set", 32'(bus_a.ovf_o), 1);
        tick(20);
        chk("ovf_sticky",   32'(bus_a.ovf_o), 1);
        chk("ovf_no_valid", 32'(va_cnt - base), 0);
        chk("ovf_hold_per", 32'(bus_a.period_o), 100);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_clr", 32'(bus_a.ovf_o), 0);
        en_a = 1'b0; pwm = 1'b0;
        tick(5);

        // enable dropped mid low phase, then re-enable with pwm high
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        pwm = 1'b1; tick(30);
        pwm = 1'b0; tick(40);
        en_a = 1'b0; tick(30);
        pwm = 1'b1; tick(10);
        chk("drop_no_valid", 32'(va_cnt - base), 0);
        chk("drop_period",   32'(bus_a.period_o), 100);
        chk("drop_high",     32'(bus_a.high_o), 70);
        exp_per = 50; exp_high = 20;
        en_a = 1'b1;
        tick(10);
        pwm = 1'b0; tick(30);
        drive_pwm(50, 20, 1);
        tick(5);
        chk("reen_count",  32'(va_cnt - base), 1);
        chk("reen_values", 32'(va_bad), 0);
        chk("reen_period", 32'(bus_a.period_o), 50);
        chk("reen_high",   32'(bus_a.high_o), 20);
        en_a = 1'b0; pwm = 1'b0;
        tick(5);

        // loopback of a generator channel: period 16, quarter duty
        exp_per = 16; exp_high = 4;
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        drive_pwm(16, 4, 3);
        tick(5);
        chk("loop_count",  32'(va_cnt - base), 3);
        chk("loop_values", 32'(va_bad), 0);
        chk("loop_period", 32'(bus_a.period_o), 16);
        chk("loop_high",   32'(bus_a.high_o), 4);
        en_a = 1'b0; pwm = 1'b0;
        tick(5);

        // one-cycle pulses every three cycles
        exp_per = 3; exp_high = 1;
        base = va_cnt;
        en_a = 1'b1;
        tick(5);
        drive_pwm(3, 1, 5);
        tick(5);
        chk("short_count",  32'(va_cnt - base), 5);
        chk("short_values", 32'(va_bad), 0);
        chk("short_period", 32'(bus_a.period_o), 3);
        chk("short_high",   32'(bus_a.high_o), 1);
        en_a = 1'b0; pwm = 1'b0;
        tick(5);

        // CntDw=4: rise arrives exactly at cnt==15, edge wins over saturation
        exp_per = 15; exp_high = 5;
        en_b = 1'b1;
        tick(5);
        drive_pwm(15, 5, 2);
        tick(5);
        chk("coin_count",  32'(vb_cnt), 2);
        chk("coin_values", 32'(vb_bad), 0);
        chk("coin_period", 32'(bus_b.period_o), 15);
        chk("coin_high",   32'(bus_b.high_o), 5);
        chk("coin_no_ovf", 32'(bus_b.ovf_o), 0);
        tick(20);
        chk("b_sat_ovf",   32'(bus_b.ovf_o), 1);
        en_b = 1'b0; pwm = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
